// File: rtl/mix_pkg.sv
// mix_pkg: lane geometry, checker FSM states and the mix_round
// permutation that predicts the next frame of a stream.
package mix_pkg;

  localparam int LANES  = 8;
  localparam int WORD_W = 32;
  localparam int LANE_W = 3;

  localparam logic [WORD_W-1:0] MIX_K = 32'h9E37_79B1;
  localparam logic [WORD_W-1:0] MIX_C = 32'h6A09_E667;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LANES-1:0][WORD_W-1:0] lanes_t;

  typedef enum logic [1:0] {
    SEED,
    CHECK,
    PREDICT
  } state_t;

  // lane 0 sits in the low word
  localparam lanes_t REF_INIT = {
    32'd7, 32'd6, 32'd5, 32'd4,
    32'd3, 32'd2, 32'd1, 32'd0
  };

  // steps run in lane order; each step sees lanes already updated
  function automatic lanes_t mix_round(lanes_t s);
    lanes_t x;
    logic [LANE_W-1:0] j;
    logic [LANE_W-1:0] n;
    logic [LANE_W-1:0] p;
    x = s;
    for (int i = 0; i < LANES; i++) begin
      j = LANE_W'(i);
      n = j + 3'd1;
      p = j - 3'd1;
      x[j] = (x[j] ^ (x[n] >> 5))
           + x[p] * MIX_K
           + (MIX_C ^ WORD_W'(i));
    end
    return x;
  endfunction

endpackage

// File: rtl/mix_stream_checker_if.sv
// mix_stream_checker_if: valid/ready word stream into the checker.
// master drives words, slave accepts them.
interface mix_stream_checker_if
  import mix_pkg::*;
();

  logic  in_valid;
  logic  in_ready;
  word_t in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/mix_stream_checker.sv
// mix_stream_checker: seeds on one 8-word frame, then checks every
// following frame against mix_round of the previous one.
module mix_stream_checker
  import mix_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  mix_stream_checker_if.slave s,
  output logic                frame_ok,
  output logic                err_valid,
  output logic [LANE_W-1:0]   err_lane,
  output logic [15:0]         err_frame,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         mismatch_cnt,
  output logic                fail
);

  state_t            state;
  logic [LANE_W-1:0] lane;
  lanes_t            cur;
  lanes_t            pred;
  logic              rdy;
  logic              all_ok;

  logic acc;
  logic mism;
  logic last;

  assign acc  = s.in_valid && rdy;
  assign mism = s.in_data != pred[lane];
  assign last = lane == LANE_W'(LANES - 1);

  assign s.in_ready = rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEED;
      lane         <= '0;
      cur          <= '0;
      pred         <= '0;
      rdy          <= 1'b0;
      all_ok       <= 1'b1;
      frame_ok     <= 1'b0;
      err_valid    <= 1'b0;
      err_lane     <= '0;
      err_frame    <= '0;
      frame_cnt    <= '0;
      mismatch_cnt <= '0;
      fail         <= 1'b0;
    end else if (clear) begin
      state        <= SEED;
      lane         <= '0;
      rdy          <= 1'b1;
      all_ok       <= 1'b1;
      frame_ok     <= 1'b0;
      err_valid    <= 1'b0;
      err_lane     <= '0;
      err_frame    <= '0;
      frame_cnt    <= '0;
      mismatch_cnt <= '0;
      fail         <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      err_valid <= 1'b0;
      unique case (state)
        SEED: begin
          rdy <= 1'b1;
          if (acc) begin
            cur[lane] <= s.in_data;
            lane      <= lane + 3'd1;
            if (last) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= PREDICT;
              rdy       <= 1'b0;
            end
          end
        end
        PREDICT: begin
          pred   <= mix_round(cur);
          state  <= CHECK;
          rdy    <= 1'b1;
          all_ok <= 1'b1;
        end
        CHECK: begin
          if (acc) begin
            // a bad word still becomes cur so the next frame resyncs
            cur[lane] <= s.in_data;
            lane      <= lane + 3'd1;
            if (mism) begin
              err_valid <= 1'b1;
              err_lane  <= lane;
              err_frame <= frame_cnt;
              fail      <= 1'b1;
              all_ok    <= 1'b0;
              if (mismatch_cnt != 16'hFFFF)
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
            if (last) begin
              frame_ok  <= all_ok && !mism;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= PREDICT;
              rdy       <= 1'b0;
            end
          end
        end
        default: begin
          state <= SEED;
          lane  <= '0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_stream_checker.sv
// tb_mix_stream_checker: scoreboard bench, table-driven stream
// scenarios plus reset, clear and counter saturation sequences.
module tb_mix_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        frame_ok;
  logic        err_valid;
  logic        fail;
  logic [2:0]  err_lane;
  logic [15:0] err_frame;
  logic [15:0] frame_cnt;
  logic [15:0] mismatch_cnt;

  mix_stream_checker_if ifc ();

  mix_stream_checker dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .s            (ifc.slave),
    .frame_ok     (frame_ok),
    .err_valid    (err_valid),
    .err_lane     (err_lane),
    .err_frame    (err_frame),
    .frame_cnt    (frame_cnt),
    .mismatch_cnt (mismatch_cnt),
    .fail         (fail)
  );

  always #5 clk = ~clk;

  typedef logic [7:0][31:0] blk_t;

  typedef struct {
    bit          is_err;
    logic [2:0]  lane;
    logic [15:0] frame;
    logic [15:0] cnt;
  } ev_t;

  typedef struct {
    bit          gaps;
    int          cf;
    logic [2:0]  cl;
    logic [31:0] mask;
    logic [15:0] fc;
    logic [15:0] mc;
    bit          fl;
    int          lows;
  } scn_t;

  ev_t  sbq[$];
  ev_t  ev;
  int   tests = 0;
  int   fails = 0;
  int   lows  = 0;
  bit   low_en = 1'b0;

  bit          m_seed;
  logic [2:0]  m_lane;
  blk_t        m_cur;
  blk_t        m_exp;
  logic [15:0] m_frame;
  logic [15:0] m_mis;
  bit          m_ok;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // independent reference of the round: logical shift spelled as a slice
  function automatic blk_t ref_mix(input blk_t a);
    blk_t        v;
    logic [31:0] nb;
    logic [31:0] pv;
    logic [2:0]  ki;
    v = a;
    for (int k = 0; k < 8; k++) begin
      ki = 3'(k);
      nb = v[ki + 3'd1];
      pv = v[ki + 3'd7];
      v[ki] = (v[ki] ^ {5'b0, nb[31:5]}) + pv * 32'h9E3779B1
            + (32'h6A09E667 ^ 32'(k));
    end
    return v;
  endfunction

  task automatic model_reset();
    m_seed  = 1'b1;
    m_lane  = '0;
    m_cur   = '0;
    m_exp   = '0;
    m_frame = '0;
    m_mis   = '0;
    m_ok    = 1'b1;
  endtask

  task automatic model_accept(input logic [31:0] d);
    ev_t e;
    if (!m_seed && d !== m_exp[m_lane]) begin
      if (m_mis != 16'hFFFF) m_mis++;
      e.is_err = 1'b1;
      e.lane   = m_lane;
      e.frame  = m_frame;
      e.cnt    = m_mis;
      sbq.push_back(e);
      m_ok = 1'b0;
    end
    m_cur[m_lane] = d;
    if (m_lane == 3'd7) begin
      if (!m_seed && m_ok) begin
        e.is_err = 1'b0;
        e.lane   = '0;
        e.frame  = m_frame;
        e.cnt    = m_mis;
        sbq.push_back(e);
      end
      m_seed = 1'b0;
      m_ok   = 1'b1;
      m_frame++;
      m_exp = ref_mix(m_cur);
    end
    m_lane++;
  endtask

  always @(posedge clk) begin
    #1;
    if (low_en && !ifc.in_ready) lows++;
    if (frame_ok || err_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'({frame_ok, err_valid}), 32'd0);
      end else begin
        ev = sbq.pop_front();
        chk("pulse_kind", 32'(err_valid), 32'(ev.is_err));
        chk("pulse_ok", 32'(frame_ok), 32'(!ev.is_err));
        if (ev.is_err) begin
          chk("err_lane", 32'(err_lane), 32'(ev.lane));
          chk("err_frame", 32'(err_frame), 32'(ev.frame));
          chk("err_cnt", 32'(mismatch_cnt), 32'(ev.cnt));
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit gaps);
    int g;
    g = 0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && g < 16) begin
      @(negedge clk);
      g++;
    end
    if (g >= 16) chk("ready_timeout", 32'(ifc.in_ready), 32'd1);
    else model_accept(d);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_errv", 32'(err_valid), 32'd0);
    chk("rst_lane", 32'(err_lane), 32'd0);
    chk("rst_frame", 32'(err_frame), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_mcnt", 32'(mismatch_cnt), 32'd0);
    rst = 1'b0;
    sbq.delete();
    model_reset();
    @(posedge clk);
    #1 chk("ready_after_rst", 32'(ifc.in_ready), 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scn_t        tbl[4];
    logic [31:0] w;

    tbl[0] = '{1'b0, 0, 3'd0, 32'd0,        16'd4, 16'd0, 1'b0, 4};
    tbl[1] = '{1'b0, 2, 3'd5, 32'd1,        16'd4, 16'd1, 1'b1, 4};
    tbl[2] = '{1'b1, 0, 3'd0, 32'd0,        16'd4, 16'd0, 1'b0, 4};
    tbl[3] = '{1'b1, 3, 3'd7, 32'hFFFFFFFF, 16'd4, 16'd1, 1'b1, 4};

    for (int t = 0; t < 4; t++) begin
      do_reset();
      lows   = 0;
      low_en = 1'b1;
      for (int i = 0; i < 8; i++) send(32'(i), tbl[t].gaps);
      for (int f = 1; f <= 3; f++) begin
        for (int i = 0; i < 8; i++) begin
          w = m_exp[3'(i)];
          if (f == tbl[t].cf && 3'(i) == tbl[t].cl) w = w ^ tbl[t].mask;
          send(w, tbl[t].gaps);
        end
      end
      settle();
      low_en = 1'b0;
      chk("scn_fcnt", 32'(frame_cnt), 32'(tbl[t].fc));
      chk("scn_mcnt", 32'(mismatch_cnt), 32'(tbl[t].mc));
      chk("scn_fail", 32'(fail), 32'(tbl[t].fl));
      chk("scn_ready_lows", 32'(lows), 32'(tbl[t].lows));
    end

    // async reset mid-frame abandons the partial frame
    do_reset();
    for (int i = 0; i < 8; i++) send(32'(i * 3 + 1), 1'b0);
    for (int i = 0; i < 4; i++) send(m_exp[3'(i)], 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ifc.in_ready), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    chk("arst_errv", 32'(err_valid), 32'd0);
    chk("arst_ok", 32'(frame_ok), 32'd0);
    chk("arst_sb", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    model_reset();
    for (int i = 0; i < 8; i++) send(32'(i + 40), 1'b0);
    for (int i = 0; i < 8; i++) send(m_exp[3'(i)], 1'b0);
    settle();
    chk("arst_resync_fcnt", 32'(frame_cnt), 32'd2);
    chk("arst_resync_fail", 32'(fail), 32'd0);

    // clear beats a simultaneous handshake
    do_reset();
    for (int i = 0; i < 8; i++) send(32'(i + 100), 1'b0);
    send(m_exp[0] ^ 32'd1, 1'b0);
    send(m_exp[1], 1'b0);
    repeat (2) @(posedge clk);
    #2 chk("pre_clear_fail", 32'(fail), 32'd1);
    @(negedge clk);
    clear        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    chk("clr_fcnt", 32'(frame_cnt), 32'd0);
    chk("clr_mcnt", 32'(mismatch_cnt), 32'd0);
    chk("clr_fail", 32'(fail), 32'd0);
    chk("clr_ready", 32'(ifc.in_ready), 32'd1);
    chk("clr_sb", 32'(sbq.size()), 32'd0);
    sbq.delete();
    model_reset();
    for (int i = 0; i < 8; i++) send(32'(i + 7), 1'b0);
    for (int i = 0; i < 8; i++) send(m_exp[3'(i)], 1'b0);
    settle();
    chk("clr_resync_fcnt", 32'(frame_cnt), 32'd2);
    chk("clr_resync_mcnt", 32'(mismatch_cnt), 32'd0);

    // every lane wrong: mismatch counter must stick at 0xFFFF
    do_reset();
    for (int i = 0; i < 8; i++) send(32'(i), 1'b0);
    for (int f = 0; f < 8200; f++)
      for (int i = 0; i < 8; i++) send(~m_exp[3'(i)], 1'b0);
    settle();
    chk("sat_mcnt", 32'(mismatch_cnt), 32'h0000FFFF);
    chk("sat_fcnt", 32'(frame_cnt), 32'd8201);
    chk("sat_fail", 32'(fail), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
